// File: rtl/wb_regfile.sv
// Write-back stage register file: 16 x 32-bit registers, write-through
// bypass on both read ports, registered write-back echo and retired count.
module wb_regfile (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        In_Valid,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC_Current,
    input  logic [31:0] Alu_Result,
    input  logic [31:0] Ld_Result,
    input  logic        IsLd,
    input  logic        IsCall,
    input  logic        IsWb,
    input  logic [3:0]  Rd_Addr1,
    input  logic [3:0]  Rd_Addr2,
    output logic [31:0] Rd_Data1,
    output logic [31:0] Rd_Data2,
    output logic        Wb_En,
    output logic [3:0]  Wb_Addr,
    output logic [31:0] Wb_Data,
    output logic [31:0] Retired_Count
);

    logic [31:0] r_regs [16];
    logic        r_wb_en;
    logic [3:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic [31:0] r_retired;

    logic        w_wr_en;
    logic [3:0]  w_dest;
    logic [31:0] w_wdata;
    logic [31:0] w_ret_addr;
    logic        w_byp1;
    logic        w_byp2;

    // Reset kills the strobe, so a write and its bypass vanish together.
    assign w_wr_en    = In_Valid & IsWb & ~Reset;
    assign w_ret_addr = PC_Current + 32'd4;
    assign w_dest     = IsCall ? 4'd15 : Instruction[25:22];

    // Write-data select: a call always links, even if IsLd is also set.
    always_comb begin
        w_wdata = Alu_Result;
        if (IsCall)
            w_wdata = w_ret_addr;
        else if (IsLd)
            w_wdata = Ld_Result;
    end

    assign w_byp1 = w_wr_en && (Rd_Addr1 == w_dest);
    assign w_byp2 = w_wr_en && (Rd_Addr2 == w_dest);

    assign Rd_Data1 = w_byp1 ? w_wdata : r_regs[Rd_Addr1];
    assign Rd_Data2 = w_byp2 ? w_wdata : r_regs[Rd_Addr2];

    assign Wb_En         = r_wb_en;
    assign Wb_Addr       = r_wb_addr;
    assign Wb_Data       = r_wb_data;
    assign Retired_Count = r_retired;

    // Register array update; only the destination changes on a strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++)
                r_regs[i] <= 32'd0;
        end else if (w_wr_en) begin
            r_regs[w_dest] <= w_wdata;
        end
    end

    // Write-back echo; address and data hold when no write retires.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= 4'd0;
            r_wb_data <= 32'd0;
        end else begin
            r_wb_en <= w_wr_en;
            if (w_wr_en) begin
                r_wb_addr <= w_dest;
                r_wb_data <= w_wdata;
            end
        end
    end

    // Saturating count of every valid instruction consumed.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_retired <= 32'd0;
        else if (In_Valid && (r_retired != 32'hFFFF_FFFF))
            r_retired <= r_retired + 32'd1;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: write select, bypass, echo,
// reset priority and retired-count saturation.
module tb_wb_regfile;

    logic        Clk;
    logic        Reset;
    logic        In_Valid;
    logic [31:0] Instruction;
    logic [31:0] PC_Current;
    logic [31:0] Alu_Result;
    logic [31:0] Ld_Result;
    logic        IsLd;
    logic        IsCall;
    logic        IsWb;
    logic [3:0]  Rd_Addr1;
    logic [3:0]  Rd_Addr2;
    logic [31:0] Rd_Data1;
    logic [31:0] Rd_Data2;
    logic        Wb_En;
    logic [3:0]  Wb_Addr;
    logic [31:0] Wb_Data;
    logic [31:0] Retired_Count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cnt;

    wb_regfile dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .In_Valid      (In_Valid),
        .Instruction   (Instruction),
        .PC_Current    (PC_Current),
        .Alu_Result    (Alu_Result),
        .Ld_Result     (Ld_Result),
        .IsLd          (IsLd),
        .IsCall        (IsCall),
        .IsWb          (IsWb),
        .Rd_Addr1      (Rd_Addr1),
        .Rd_Addr2      (Rd_Addr2),
        .Rd_Data1      (Rd_Data1),
        .Rd_Data2      (Rd_Data2),
        .Wb_En         (Wb_En),
        .Wb_Addr       (Wb_Addr),
        .Wb_Data       (Wb_Data),
        .Retired_Count (Retired_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic v, input logic wb, input logic ld,
                         input logic call, input logic [3:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] ldr);
        In_Valid    = v;
        IsWb        = wb;
        IsLd        = ld;
        IsCall      = call;
        Instruction = 32'h0;
        Instruction[25:22] = rd;
        PC_Current  = pc;
        Alu_Result  = alu;
        Ld_Result   = ldr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle();
        Rd_Addr1 = 4'd0;
        Rd_Addr2 = 4'd15;
        step();
        step();
        Reset = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++;
        if (Wb_En !== 1'b0 || Wb_Addr !== 4'd0 || Wb_Data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wb: en=%b addr=%0d data=%h want 0/0/0",
                     Wb_En, Wb_Addr, Wb_Data);
        end
        n_checks++;
        if (Retired_Count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %h want 0", Retired_Count);
        end
        n_checks++;
        if (Rd_Data1 !== 32'd0 || Rd_Data2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: r0=%h r15=%h want 0", Rd_Data1, Rd_Data2);
        end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0, 32'h12345678, 32'h0);
        step();
        exp_cnt++;
        idle();
        Rd_Addr1 = 4'd3;
        #1;
        n_checks++;
        if (Wb_En !== 1'b1 || Wb_Addr !== 4'd3 || Wb_Data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL alu_wb: en=%b addr=%0d data=%h want 1/3/12345678",
                     Wb_En, Wb_Addr, Wb_Data);
        end
        n_checks++;
        if (Rd_Data1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL alu_read: got %h want 12345678", Rd_Data1);
        end
        n_checks++;
        if (Retired_Count !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_count: got %h want 1", Retired_Count);
        end
    endtask

    task automatic test_load_bypass();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 32'h1, 32'hDEADBEEF);
        Rd_Addr1 = 4'd5;
        Rd_Addr2 = 4'd5;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'hDEADBEEF || Rd_Data2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ld_bypass: p1=%h p2=%h want deadbeef", Rd_Data1, Rd_Data2);
        end
        step();
        exp_cnt++;
        idle();
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'hDEADBEEF || Wb_Data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL ld_stored: r5=%h wbdata=%h want deadbeef",
                     Rd_Data1, Wb_Data);
        end
    endtask

    task automatic test_call();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0, 32'h00000022, 32'h0);
        step();
        exp_cnt++;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h00000100, 32'h5, 32'h999);
        Rd_Addr1 = 4'd15;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000104) begin
            n_fail++;
            $display("FAIL call_bypass: got %h want 00000104", Rd_Data1);
        end
        step();
        exp_cnt++;
        idle();
        Rd_Addr1 = 4'd15;
        Rd_Addr2 = 4'd2;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000104 || Rd_Data2 !== 32'h00000022) begin
            n_fail++;
            $display("FAIL call_link: r15=%h r2=%h want 00000104/00000022",
                     Rd_Data1, Rd_Data2);
        end
        n_checks++;
        if (Wb_Addr !== 4'd15) begin
            n_fail++;
            $display("FAIL call_wbaddr: got %0d want 15", Wb_Addr);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'hFFFFFFFC, 32'h5, 32'h0);
        step();
        exp_cnt++;
        idle();
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000000 || Rd_Data2 !== 32'h00000022) begin
            n_fail++;
            $display("FAIL call_wrap: r15=%h r2=%h want 00000000/00000022",
                     Rd_Data1, Rd_Data2);
        end
    endtask

    task automatic test_invalid_and_store();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0, 32'h00000077, 32'h0);
        step();
        exp_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0, 32'h00000BAD, 32'h0);
        Rd_Addr1 = 4'd7;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000077) begin
            n_fail++;
            $display("FAIL inval_nobypass: got %h want 00000077", Rd_Data1);
        end
        step();
        #1;
        n_checks++;
        if (Wb_En !== 1'b0 || Wb_Addr !== 4'd7 || Wb_Data !== 32'h77) begin
            n_fail++;
            $display("FAIL inval_wb: en=%b addr=%0d data=%h want 0/7/00000077",
                     Wb_En, Wb_Addr, Wb_Data);
        end
        n_checks++;
        if (Rd_Data1 !== 32'h00000077 || Retired_Count !== exp_cnt) begin
            n_fail++;
            $display("FAIL inval_state: r7=%h cnt=%h want 00000077/%h",
                     Rd_Data1, Retired_Count, exp_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h0, 32'h00000BAD, 32'h0);
        step();
        exp_cnt++;
        idle();
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000077 || Wb_En !== 1'b0 ||
            Retired_Count !== exp_cnt) begin
            n_fail++;
            $display("FAIL store: r7=%h en=%b cnt=%h want 00000077/0/%h",
                     Rd_Data1, Wb_En, Retired_Count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h0, 32'h00000001, 32'h0);
        step();
        exp_cnt++;
        n_checks++;
        if (Wb_Data !== 32'h1 || Wb_Addr !== 4'd4) begin
            n_fail++;
            $display("FAIL b2b_first: addr=%0d data=%h want 4/00000001",
                     Wb_Addr, Wb_Data);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h0, 32'h00000002, 32'h0);
        Rd_Addr1 = 4'd4;
        Rd_Addr2 = 4'd3;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h2 || Rd_Data2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b_bypass: r4=%h r3=%h want 00000002/12345678",
                     Rd_Data1, Rd_Data2);
        end
        step();
        exp_cnt++;
        idle();
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h2 || Wb_Data !== 32'h2 ||
            Retired_Count !== exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_final: r4=%h wbdata=%h cnt=%h want 2/2/%h",
                     Rd_Data1, Wb_Data, Retired_Count, exp_cnt);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0, 32'h00000099, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0, 32'hAAAA5555, 32'h0);
        Reset = 1'b1;
        Rd_Addr1 = 4'd9;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h00000099) begin
            n_fail++;
            $display("FAIL rst_read: got %h want 00000099", Rd_Data1);
        end
        step();
        Reset = 1'b0;
        idle();
        exp_cnt = 0;
        #1;
        n_checks++;
        if (Rd_Data1 !== 32'h0 || Wb_En !== 1'b0 || Retired_Count !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_prio: r9=%h en=%b cnt=%h want 0/0/0",
                     Rd_Data1, Wb_En, Retired_Count);
        end
    endtask

    task automatic test_saturation();
        force dut.r_retired = 32'hFFFFFFFE;
        #1;
        release dut.r_retired;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (Retired_Count !== 32'hFFFFFFFF) begin
                n_fail++;
                $display("FAIL sat_%0d: got %h want ffffffff", i, Retired_Count);
            end
        end
        idle();
    endtask

    initial begin
        Reset    = 1'b1;
        Rd_Addr1 = 4'd0;
        Rd_Addr2 = 4'd0;
        exp_cnt  = 0;
        idle();
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_call();
        test_invalid_and_store();
        test_back_to_back();
        test_reset_priority();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
